// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - state/op encodings and default widths for the data-memory stage
package dmem_pkg;
   localparam int DMEM_N           = 64;
   localparam int DMEM_DEPTH_LOG2  = 8;
   localparam int DMEM_WAIT_CYCLES = 2;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] WAIT = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   typedef enum logic {
      OP_LD = 1'b0,
      OP_ST = 1'b1
   } op_t;
endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - doubleword storage: synchronous write, combinational read
module dmem_array
   import dmem_pkg::*;
#(
   parameter int N          = DMEM_N,
   parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
   input  logic                  Clk,
   input  logic                  WriteEn,
   input  logic [DEPTH_LOG2-1:0] Index,
   input  logic [N-1:0]          WriteData,
   output logic [N-1:0]          ReadData
);
   logic [N-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge Clk) begin
      if (WriteEn) mem[Index] <= WriteData;
   end

   assign ReadData = mem[Index];
endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - LDUR/STUR data-memory controller with wait states
// Optional alignment fault checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int N           = DMEM_N,
   parameter int DEPTH_LOG2  = DMEM_DEPTH_LOG2,
   parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
   input  logic         Clk,
   input  logic         ResetL,
   input  logic         Req,
   input  logic         MemRead,
   input  logic         MemWrite,
   input  logic [N-1:0] Address,
   input  logic [N-1:0] WriteData,
   output logic [N-1:0] ReadData,
   output logic         Busy,
   output logic         Ready,
   output logic         Fault
);
   localparam int CW = $clog2(WAIT_CYCLES + 2);

   logic [1:0]            state;
   logic [CW-1:0]         count;
   op_t                   op;
   logic [DEPTH_LOG2-1:0] wordIdx;
   logic [N-1:0]          wrData;
   logic [N-1:0]          rdWord;
   logic                  accept;
   logic                  commit;
   logic                  misaligned;
   logic                  unusedAddr;

   assign accept     = Req && (MemRead ^ MemWrite);
   assign commit     = (state == WAIT) && (count == '0);
   assign Busy       = (state != IDLE);
   assign Ready      = (state == DONE);
   assign unusedAddr = ^{Address[N-1:DEPTH_LOG2+3], Address[2:0]};

`ifdef DMEM_ALIGN_CHECK_EN
   logic [2:0] byteOff;

   always_ff @(posedge Clk or negedge ResetL) begin
      if (!ResetL)                        byteOff <= 3'b000;
      else if (state == IDLE && accept)   byteOff <= Address[2:0];
   end

   assign misaligned = (byteOff != 3'b000);
   assign Fault      = Ready && misaligned;
`else
   assign misaligned = 1'b0;
   assign Fault      = 1'b0;
`endif

   dmem_array #(
      .N          (N),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .Clk       (Clk),
      .WriteEn   (commit && (op == OP_ST) && !misaligned),
      .Index     (wordIdx),
      .WriteData (wrData),
      .ReadData  (rdWord)
   );

   // Counter starts at WAIT_CYCLES+1 so Ready lands WAIT_CYCLES+2 edges after accept.
   always_ff @(posedge Clk or negedge ResetL) begin
      if (!ResetL) begin
         state    <= IDLE;
         count    <= '0;
         op       <= OP_LD;
         wordIdx  <= '0;
         wrData   <= '0;
         ReadData <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op      <= MemWrite ? OP_ST : OP_LD;
                  wordIdx <= Address[DEPTH_LOG2+2:3];
                  wrData  <= WriteData;
                  count   <= CW'(WAIT_CYCLES + 1);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (count != '0) begin
                  count <= count - CW'(1);
               end else begin
                  if (op == OP_LD && !misaligned) ReadData <= rdWord;
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
